// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill controller.
// State encodings are externally visible on the state port.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HIT_RESP  = 3'd1,
        MEM_REQ   = 3'd2,
        REFILL    = 3'd3,
        FILL_DONE = 3'd4
    } state_t;

    localparam int unsigned STATE_W = 3;

    // Byte-offset bits within one word.
    function automatic int unsigned word_off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Byte-offset bits within one cache line.
    function automatic int unsigned line_off_w(input int unsigned data_w,
                                               input int unsigned line_words);
        return word_off_w(data_w) + $clog2(line_words);
    endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Beat index and beat count for one line refill.
// The index may start mid-line and wraps; the count always runs 0..LINE_WORDS-1.
module refill_beat_counter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [$clog2(LINE_WORDS)-1:0] start_idx,
    input  logic                          inc,
    output logic [$clog2(LINE_WORDS)-1:0] idx,
    output logic                          first,
    output logic                          last
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            idx_q <= start_idx;
            cnt_q <= '0;
        end else if (inc) begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign idx   = idx_q;
    assign first = (cnt_q == '0);
    assign last  = (cnt_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: hit response, memory request, line refill.
// Optional macro CRIT_WORD_FIRST_EN: critical-word-first fetch with early response.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          read_en,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          hit,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_err,
    output logic                          refill_we,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
    output logic [DATA_W-1:0]             refill_data,
    output logic                          fill_done,
    output logic                          resp_valid,
    output logic                          resp_err,
    output logic                          busy,
    output logic [STATE_W-1:0]            state
);

    localparam int unsigned IDX_W    = $clog2(LINE_WORDS);
    localparam int unsigned WORD_OFF = word_off_w(DATA_W);
    localparam int unsigned LINE_OFF = line_off_w(DATA_W, LINE_WORDS);

`ifdef CRIT_WORD_FIRST_EN
    localparam int unsigned ALIGN_BITS = WORD_OFF;
`else
    localparam int unsigned ALIGN_BITS = LINE_OFF;
`endif
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              accept_miss;
    logic              beat_load, beat_inc, beat_first, beat_last;
    logic [IDX_W-1:0]  beat_start, beat_idx;

    assign accept_miss = (state_q == IDLE) && read_en && !hit;

`ifdef CRIT_WORD_FIRST_EN
    assign beat_start = req_addr[LINE_OFF-1:WORD_OFF];
`else
    assign beat_start = '0;
    logic unused_first;
    assign unused_first = beat_first;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_miss) addr_q <= req_addr;
        end
    end

    refill_beat_counter #(
        .LINE_WORDS(LINE_WORDS)
    ) u_beat (
        .clk      (clk),
        .rst      (rst),
        .load     (beat_load),
        .start_idx(beat_start),
        .inc      (beat_inc),
        .idx      (beat_idx),
        .first    (beat_first),
        .last     (beat_last)
    );

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        refill_we  = 1'b0;
        beat_load  = 1'b0;
        beat_inc   = 1'b0;
        fill_done  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_en) begin
                    if (hit) begin
                        state_d = HIT_RESP;
                    end else begin
                        state_d   = MEM_REQ;
                        beat_load = 1'b1;
                    end
                end
            end
            HIT_RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            MEM_REQ: begin
                mem_req = 1'b1;
                if (mem_err) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = IDLE;
                end else if (mem_gnt) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                // An error beat is never written, even if rvalid is also high.
                if (mem_err) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = IDLE;
                end else if (mem_rvalid) begin
                    refill_we = 1'b1;
                    beat_inc  = 1'b1;
`ifdef CRIT_WORD_FIRST_EN
                    resp_valid = beat_first;
`endif
                    if (beat_last) state_d = FILL_DONE;
                end
            end
            FILL_DONE: begin
                fill_done = 1'b1;
`ifndef CRIT_WORD_FIRST_EN
                resp_valid = 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr    = addr_q & ADDR_MASK;
    assign refill_idx  = beat_idx;
    assign refill_data = mem_rdata;
    assign busy        = (state_q != IDLE);
    assign state       = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl; expectations follow CRIT_WORD_FIRST_EN.
module tb_cache_refill_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LW     = 4;
`ifdef CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    localparam int K_WE = 0, K_FD = 1, K_RSP = 2;

    logic              clk, rst, read_en, hit;
    logic [ADDR_W-1:0] req_addr, mem_addr;
    logic              mem_req, mem_gnt, mem_rvalid, mem_err;
    logic [DATA_W-1:0] mem_rdata, refill_data;
    logic              refill_we, fill_done, resp_valid, resp_err, busy;
    logic [1:0]        refill_idx;
    logic [2:0]        state;

    cache_refill_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LINE_WORDS(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read_en    (read_en),
        .req_addr   (req_addr),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .refill_we  (refill_we),
        .refill_idx (refill_idx),
        .refill_data(refill_data),
        .fill_done  (fill_done),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [1:0]  idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int kind, input logic [1:0] idx,
                            input logic [31:0] data, input logic err);
        exp_t e;
        e.kind = kind; e.idx = idx; e.data = data; e.err = err;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per observed output event, in fixed order.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (refill_we) begin
                    ok = (q.size() != 0) && (q[0].kind == K_WE);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL refill_we_expected: got write idx=%0d data=%h, required none", refill_idx, refill_data);
                    end else begin
                        e = q.pop_front();
                        chk("refill_idx", 32'(refill_idx), 32'(e.idx));
                        chk("refill_data", refill_data, e.data);
                    end
                end
                if (fill_done) begin
                    ok = (q.size() != 0) && (q[0].kind == K_FD);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL fill_done_expected: got 1, required 0 (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                    end
                end
                if (resp_valid) begin
                    ok = (q.size() != 0) && (q[0].kind == K_RSP);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL resp_valid_expected: got 1, required 0 (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic do_hit(input logic [31:0] addr);
        cyc();
        read_en = 1'b1; hit = 1'b1; req_addr = addr;
        push_exp(K_RSP, 2'd0, '0, 1'b0);
        @(negedge clk);
        chk("hit_state_req", 32'(state), 32'd0);
        cyc();
        read_en = 1'b0; hit = 1'b0;
        @(negedge clk);
        chk("hit_state_resp", 32'(state), 32'd1);
        chk("hit_mem_req", 32'(mem_req), 32'd0);
        cyc();
        @(negedge clk);
        chk("hit_state_back", 32'(state), 32'd0);
        chk("hit_busy_back", 32'(busy), 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input int gnt_wait,
                           input logic [15:0] pat, input int pat_len, input int err_beat);
        logic [31:0] exp_addr;
        logic [1:0]  start;
        logic [31:0] d;
        int          beat;
        bit          aborted;
        exp_addr = CWF ? (addr & 32'hFFFF_FFFC) : (addr & 32'hFFFF_FFF0);
        start    = CWF ? addr[3:2] : 2'd0;
        beat     = 0;
        aborted  = 1'b0;
        cyc();
        read_en = 1'b1; hit = 1'b0; req_addr = addr;
        @(negedge clk);
        chk("miss_state_req", 32'(state), 32'd0);
        cyc();
        read_en = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            mem_gnt = (i == gnt_wait - 1);
            @(negedge clk);
            chk("memreq_state", 32'(state), 32'd2);
            chk("memreq_mem_req", 32'(mem_req), 32'd1);
            chk("memreq_mem_addr", mem_addr, exp_addr);
            cyc();
        end
        mem_gnt = 1'b0;
        for (int i = 0; i < pat_len; i++) begin
            d = 32'h0000_000A + 32'(beat);
            mem_rvalid = pat[i];
            mem_rdata  = d;
            mem_err    = pat[i] && (beat == err_beat);
            if (mem_err) begin
                push_exp(K_RSP, 2'd0, '0, 1'b1);
                aborted = 1'b1;
            end else if (pat[i]) begin
                push_exp(K_WE, start + 2'(beat), d, 1'b0);
                if (CWF && beat == 0) push_exp(K_RSP, 2'd0, '0, 1'b0);
                beat++;
            end
            @(negedge clk);
            if (i == 0) begin
                chk("refill_mem_req_dropped", 32'(mem_req), 32'd0);
                chk("refill_state", 32'(state), 32'd3);
            end
            cyc();
            if (aborted) break;
        end
        mem_rvalid = 1'b0; mem_err = 1'b0;
        if (aborted) begin
            @(negedge clk);
            chk("abort_state", 32'(state), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
        end else begin
            push_exp(K_FD, 2'd0, '0, 1'b0);
            if (!CWF) push_exp(K_RSP, 2'd0, '0, 1'b0);
            @(negedge clk);
            chk("filldone_state", 32'(state), 32'd4);
            cyc();
            @(negedge clk);
            chk("after_fill_state", 32'(state), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_refill_we"}, 32'(refill_we), 32'd0);
        chk({tag, "_fill_done"}, 32'(fill_done), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    endtask

    initial begin
        rst = 1'b0; read_en = 1'b0; hit = 1'b0; req_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk_reset_outputs("reset");
        cyc();
        rst = 1'b1;

        do_hit(32'h0000_1238);
        do_miss(32'h0000_1238, 3, 16'h000F, 4, -1);
        do_miss(32'h0000_2004, 1, 16'h0059, 7, -1);
        do_miss(32'h0000_1238, 2, 16'h000F, 4, 2);
        do_hit(32'h0000_1238);

        // Error while still requesting memory.
        cyc();
        read_en = 1'b1; hit = 1'b0; req_addr = 32'h0000_4000;
        cyc();
        read_en = 1'b0; mem_err = 1'b1;
        push_exp(K_RSP, 2'd0, '0, 1'b1);
        @(negedge clk);
        chk("memreq_err_state", 32'(state), 32'd2);
        cyc();
        mem_err = 1'b0;
        @(negedge clk);
        chk("memreq_err_back", 32'(state), 32'd0);

        // Reset at beat 1 of a refill, with a read attempt during REFILL.
        cyc();
        read_en = 1'b1; hit = 1'b0; req_addr = 32'h0000_3008;
        cyc();
        read_en = 1'b0; mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_000A;
        read_en = 1'b1; hit = 1'b1;
        push_exp(K_WE, CWF ? 2'd2 : 2'd0, 32'h0000_000A, 1'b0);
        if (CWF) push_exp(K_RSP, 2'd0, '0, 1'b0);
        @(negedge clk);
        chk("rst_pre_state", 32'(state), 32'd3);
        cyc();
        rst = 1'b0; mem_rdata = 32'h0000_000B;
        @(negedge clk);
        chk_reset_outputs("midrst");
        cyc();
        read_en = 1'b0; hit = 1'b0; mem_rvalid = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_gnt = 1'b1;
            @(negedge clk);
            chk("post_rst_state", 32'(state), 32'd0);
            chk("post_rst_mem_req", 32'(mem_req), 32'd0);
            cyc();
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        repeat (3) cyc();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width; must be 32 or 64.
REQ-003 SHALL have parameter LINE_WORDS, default 4, words per line; power of two, 2..16.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports read_en in 1 request strobe; req_addr in ADDR_W request byte address; hit in 1 tag-lookup result, valid with read_en.
REQ-007 SHALL have ports mem_req out 1; mem_addr out ADDR_W; mem_gnt in 1; mem_rvalid in 1; mem_rdata in DATA_W; mem_err in 1.
REQ-008 SHALL have ports refill_we out 1; refill_idx out $clog2(LINE_WORDS); refill_data out DATA_W; fill_done out 1 (tag/valid write strobe).
REQ-009 SHALL have ports resp_valid out 1; resp_err out 1; busy out 1; state out 3.

Function
REQ-010 SHALL implement states IDLE, HIT_RESP, MEM_REQ, REFILL, FILL_DONE.
REQ-011 IDLE: read_en&hit -> HIT_RESP; read_en&!hit -> MEM_REQ and latch req_addr; otherwise stay.
REQ-012 HIT_RESP SHALL last exactly one cycle with resp_valid=1, then go to IDLE; hit response 1 cycle after read_en.
REQ-013 MEM_REQ: mem_req=1 with mem_addr stable every cycle; on mem_gnt=1 go to REFILL; mem_req SHALL drop the cycle after grant.
REQ-014 REFILL: each mem_rvalid=1 cycle SHALL assert refill_we combinationally, with refill_data=mem_rdata and refill_idx=beat index, then advance the beat index modulo LINE_WORDS.
REQ-015 After LINE_WORDS beats, the next state SHALL be FILL_DONE; FILL_DONE SHALL last one cycle with fill_done=1, then go to IDLE.
REQ-016 mem_rvalid outside REFILL SHALL be ignored; mem_gnt outside MEM_REQ SHALL be ignored.
REQ-017 mem_err=1 in MEM_REQ or REFILL SHALL abort to IDLE with a one-cycle resp_valid=1, resp_err=1; that cycle SHALL have no refill_we and fill_done SHALL never assert.
REQ-018 read_en outside IDLE SHALL be ignored, not queued.
REQ-019 busy SHALL be 1 in every state except IDLE; state SHALL output the current encoding (IDLE=0, HIT_RESP=1, MEM_REQ=2, REFILL=3, FILL_DONE=4).
REQ-020 Without error, resp_valid SHALL pulse exactly once per accepted request and resp_err SHALL stay 0.

Reset
REQ-021 rst low SHALL force IDLE and clear the beat counter and the latched address; mem_req, refill_we, fill_done, resp_valid, resp_err, busy SHALL be 0 and state SHALL be 0.
REQ-022 Reset mid-refill SHALL abandon the line; no fill_done and no response after release.

Configuration
REQ-023 Macro CRIT_WORD_FIRST_EN defined: mem_addr SHALL be the word-aligned latched address.
REQ-024 With CRIT_WORD_FIRST_EN, the beat index SHALL start at the requested word offset and wrap modulo LINE_WORDS.
REQ-025 With CRIT_WORD_FIRST_EN, resp_valid SHALL pulse with the first beat, and there SHALL be no response in FILL_DONE.
REQ-026 Macro undefined: mem_addr SHALL be line-aligned, the index SHALL start at 0, and resp_valid SHALL pulse in FILL_DONE.

Structure
REQ-027 Package cache_pkg SHALL hold the state enum typedef, the state encodings and a word/line offset-width helper function.
REQ-028 Beat index/count logic SHALL be a sub-module, refill_beat_counter (load start, increment, last-beat flag).

Verification
REQ-029 Hit: read_en=1, hit=1, addr 0x1238 -> resp_valid=1 the next cycle only; mem_req stays 0; state 0->1->0.
REQ-030 Miss, macro off, LINE_WORDS=4: addr 0x1238, grant after 3 cycles, rdata A,B,C,D -> mem_addr=0x1230; idx 0,1,2,3; fill_done then resp_valid in the same cycle.
REQ-031 Miss, CRIT_WORD_FIRST_EN: addr 0x1238 -> mem_addr=0x1238; idx 2,3,0,1; resp_valid with the first beat; fill_done alone.
REQ-032 Gapped beats: mem_rvalid 1,0,0,1,1,0,1 -> exactly 4 refill_we; FILL_DONE one cycle after the 4th beat.
REQ-033 Error: mem_err at beat 2 -> resp_valid=resp_err=1 for one cycle, no fill_done, state 0; next hit serviced normally.
REQ-034 Reset asserted mid-REFILL at beat 1, plus read_en during REFILL -> all outputs 0 and no stray response.
